// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, port IDs, byte-enable width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdResp,
        StRmwWr,
        StWrResp
    } state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_e;

    function automatic int unsigned be_width(int unsigned data_width);
        return data_width / 8;
    endfunction

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH           = be_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response ports of the arbiter plus its single-port RAM side, bundled in one interface.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned BeW = DATA_WIDTH / 8;

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_req_we;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic [BeW-1:0]        d_req_be;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_write;
    logic                  ram_read;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be,
        input  ram_data_out,
        output i_req_ready, i_resp_valid, i_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output ram_address, ram_data_in, ram_write, ram_read
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be,
        output ram_data_out,
        input  i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  ram_address, ram_data_in, ram_write, ram_read
    );

endinterface

// File: rtl/mem_byte_merge.sv
// Combinational byte merge: bytes of new_word where be is set, otherwise bytes of old_word.
module mem_byte_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   merged
);
    localparam int unsigned BeW = DATA_WIDTH / 8;

    always_comb begin
        merged = old_word;
        for (int unsigned b = 0; b < BeW; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered-output RAM between a fetch port and a load/store
// port; one transaction in flight, partial stores done as read-modify-write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned    BeW   = DATA_WIDTH / 8;
    localparam logic [BeW-1:0] BeAll = '1;

    state_e                state_q, state_d;
    port_e                 last_q, last_d;
    port_e                 port_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BeW-1:0]        be_q;

    port_e                 grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BeW-1:0]        sel_be;
    logic [DATA_WIDTH-1:0] merged;

    // Contention goes to the port that was not granted last.
    always_comb begin
        grant = PORT_I;
        if (bus.i_req_valid && bus.d_req_valid) begin
            grant = (last_q == PORT_I) ? PORT_D : PORT_I;
        end else if (bus.d_req_valid) begin
            grant = PORT_D;
        end
    end

    assign accept    = !rst && (state_q == StIdle) && (bus.i_req_valid || bus.d_req_valid);
    assign sel_addr  = (grant == PORT_D) ? bus.d_req_addr : bus.i_req_addr;
    assign sel_we    = (grant == PORT_D) && bus.d_req_we;
    assign sel_wdata = (grant == PORT_D) ? bus.d_req_wdata : '0;
    assign sel_be    = (grant == PORT_D) ? bus.d_req_be : '0;

    mem_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .old_word(bus.ram_data_out),
        .new_word(wdata_q),
        .be      (be_q),
        .merged  (merged)
    );

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        bus.i_req_ready  = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.i_resp_valid = 1'b0;
        bus.i_resp_data  = '0;
        bus.d_resp_valid = 1'b0;
        bus.d_resp_data  = '0;
        bus.ram_address  = '0;
        bus.ram_data_in  = '0;
        bus.ram_write    = 1'b0;
        bus.ram_read     = 1'b0;

        // Reset suppresses every output, including a pending RMW write.
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        bus.i_req_ready = (grant == PORT_I);
                        bus.d_req_ready = (grant == PORT_D);
                        bus.ram_address = sel_addr;
                        last_d          = grant;
                        if (!sel_we) begin
                            bus.ram_read = 1'b1;
                            state_d      = StRdResp;
                        end else if (sel_be == BeAll) begin
                            bus.ram_write   = 1'b1;
                            bus.ram_data_in = sel_wdata;
                            state_d         = StWrResp;
                        end else if (sel_be == '0) begin
                            state_d = StWrResp;
                        end else begin
                            bus.ram_read = 1'b1;
                            state_d      = StRmwWr;
                        end
                    end
                end
                StRdResp: begin
                    if (port_q == PORT_I) begin
                        bus.i_resp_valid = 1'b1;
                        bus.i_resp_data  = bus.ram_data_out;
                    end else begin
                        bus.d_resp_valid = 1'b1;
                        bus.d_resp_data  = bus.ram_data_out;
                    end
                    state_d = StIdle;
                end
                StRmwWr: begin
                    bus.ram_write   = 1'b1;
                    bus.ram_address = addr_q;
                    bus.ram_data_in = merged;
                    state_d         = StWrResp;
                end
                StWrResp: begin
                    bus.d_resp_valid = 1'b1;
                    state_d          = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= PORT_D;
            port_q  <= PORT_I;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (accept) begin
                port_q  <= grant;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                be_q    <= sel_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected responses, a negedge
// monitor pops and compares data and arrival cycle.
module tb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t iq[$];
    exp_t dq[$];
    exp_t ie, de;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RAM model with registered read data and a bench-side preload port.
    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] rdata = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_write) mem[bus.ram_address[7:0]] <= bus.ram_data_in;
        if (bus.ram_read) rdata <= mem[bus.ram_address[7:0]];
    end
    assign bus.ram_data_out = rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ram_rw_exclusive", 32'(bus.ram_read & bus.ram_write), 32'd0);
        if (bus.i_resp_valid) begin
            check("i_resp_expected", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
                ie = iq.pop_front();
                check("i_resp_data", bus.i_resp_data, ie.data);
                check("i_resp_cycle", 32'(cyc), 32'(ie.cyc));
            end
        end else begin
            check("i_resp_idle_zero", bus.i_resp_data, 32'd0);
        end
        if (bus.d_resp_valid) begin
            check("d_resp_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                de = dq.pop_front();
                check("d_resp_data", bus.d_resp_data, de.data);
                check("d_resp_cycle", 32'(cyc), 32'(de.cyc));
            end
        end else begin
            check("d_resp_idle_zero", bus.d_resp_data, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        idle(1);
        pre_we = 1'b0;
    endtask

    task automatic i_read(input logic [31:0] a, input logic [31:0] exp);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
        @(negedge clk);
        check("i_read_ready", 32'(bus.i_req_ready), 32'd1);
        check("i_read_d_ready", 32'(bus.d_req_ready), 32'd0);
        check("i_read_ram_read", 32'(bus.ram_read), 32'd1);
        check("i_read_ram_addr", bus.ram_address, a);
        iq.push_back('{data: exp, cyc: cyc + 1});
        idle(1);
        bus.i_req_valid = 1'b0;
        idle(2);
    endtask

    task automatic d_load(input logic [31:0] a, input logic [31:0] exp);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_we    = 1'b0;
        bus.d_req_be    = 4'h5;
        bus.d_req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("d_load_ready", 32'(bus.d_req_ready), 32'd1);
        check("d_load_ram_read", 32'(bus.ram_read), 32'd1);
        check("d_load_ram_write", 32'(bus.ram_write), 32'd0);
        dq.push_back('{data: exp, cyc: cyc + 1});
        idle(1);
        bus.d_req_valid = 1'b0;
        idle(2);
    endtask

    // exp_merge is the hand-computed RMW word; ignored unless be is partial.
    task automatic d_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_merge);
        logic full, none;
        full = (be == 4'hF);
        none = (be == 4'h0);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_we    = 1'b1;
        bus.d_req_wdata = wd;
        bus.d_req_be    = be;
        @(negedge clk);
        check("st_ready", 32'(bus.d_req_ready), 32'd1);
        check("st_i_ready", 32'(bus.i_req_ready), 32'd0);
        check("st_acc_ram_write", 32'(bus.ram_write), 32'(full));
        check("st_acc_ram_read", 32'(bus.ram_read), 32'(!full && !none));
        check("st_acc_ram_data_in", bus.ram_data_in, full ? wd : 32'd0);
        dq.push_back('{data: 32'd0, cyc: cyc + ((full || none) ? 1 : 2)});
        idle(1);
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        @(negedge clk);
        if (!full && !none) begin
            check("rmw_ram_write", 32'(bus.ram_write), 32'd1);
            check("rmw_ram_addr", bus.ram_address, a);
            check("rmw_ram_data_in", bus.ram_data_in, exp_merge);
        end else begin
            check("st_resp_ram_write", 32'(bus.ram_write), 32'd0);
        end
        idle(3);
    endtask

    logic [4:0] pat_i;
    logic [4:0] pat_d;

    initial begin
        rst             = 1'b1;
        pre_we          = 1'b0;
        pre_addr        = '0;
        pre_data        = '0;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h10;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h20;
        bus.d_req_we    = 1'b0;
        bus.d_req_wdata = '0;
        bus.d_req_be    = '0;
        idle(1);
        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h20, 32'h1234_5678);
        preload(8'h08, 32'hAABB_CCDD);
        preload(8'h0C, 32'hCAFE_F00D);
        preload(8'h14, 32'h5566_7788);
        preload(8'h18, 32'h0102_0304);
        @(negedge clk);
        check("rst_i_ready", 32'(bus.i_req_ready), 32'd0);
        check("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
        check("rst_ram_read", 32'(bus.ram_read), 32'd0);
        check("rst_ram_write", 32'(bus.ram_write), 32'd0);
        check("rst_ram_addr", bus.ram_address, 32'd0);
        idle(1);
        rst             = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;

        // First fetch after reset.
        i_read(32'h10, 32'hDEAD_BEEF);

        // Leave last-grant on the data port, then contend for three rounds.
        d_load(32'h20, 32'h1234_5678);
        pat_i = 5'b10001;
        pat_d = 5'b00100;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h10;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h20;
        bus.d_req_we    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_i_ready", 32'(bus.i_req_ready), 32'(pat_i[k]));
            check("rr_d_ready", 32'(bus.d_req_ready), 32'(pat_d[k]));
            if (pat_i[k]) iq.push_back('{data: 32'hDEAD_BEEF, cyc: cyc + 1});
            if (pat_d[k]) dq.push_back('{data: 32'h1234_5678, cyc: cyc + 1});
            idle(1);
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        idle(2);

        // Full store, RMW single byte, empty store, RMW two bytes.
        d_store(32'h04, 32'h1122_3344, 4'hF, 32'd0);
        i_read(32'h04, 32'h1122_3344);
        d_store(32'h08, 32'h0000_00EE, 4'h1, 32'hAABB_CCEE);
        i_read(32'h08, 32'hAABB_CCEE);
        d_store(32'h0C, 32'h9999_9999, 4'h0, 32'd0);
        check("be0_mem_unchanged", mem[8'h0C], 32'hCAFE_F00D);
        i_read(32'h0C, 32'hCAFE_F00D);
        d_store(32'h18, 32'hA1B2_C3D4, 4'hA, 32'hA102_C304);
        d_load(32'h18, 32'hA102_C304);

        // Reset lands in the RMW write cycle: no write, no response.
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h14;
        bus.d_req_we    = 1'b1;
        bus.d_req_wdata = 32'h0000_AA00;
        bus.d_req_be    = 4'h2;
        @(negedge clk);
        check("abort_accept", 32'(bus.d_req_ready), 32'd1);
        idle(1);
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        rst             = 1'b1;
        @(negedge clk);
        check("abort_ram_write", 32'(bus.ram_write), 32'd0);
        check("abort_d_resp", 32'(bus.d_resp_valid), 32'd0);
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_ram_write", 32'(bus.ram_write), 32'd0);
        check("post_abort_d_resp", 32'(bus.d_resp_valid), 32'd0);
        check("abort_mem_unchanged", mem[8'h14], 32'h5566_7788);
        idle(1);
        i_read(32'h14, 32'h5566_7788);
        d_load(32'h14, 32'h5566_7788);

        idle(3);
        check("i_queue_drained", 32'(iq.size()), 32'd0);
        check("d_queue_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the RAM and both ports; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32, word-address width passed unchanged to the RAM.
REQ-003 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 i_req_valid  input  1  instruction-fetch read request.
REQ-006 i_req_ready  output  1  instruction request accepted this cycle.
REQ-007 i_req_addr  input  ADDR_WIDTH  fetch word address.
REQ-008 i_resp_valid  output  1  one-cycle pulse; fetch data valid.
REQ-009 i_resp_data  output  DATA_WIDTH  fetch data.
REQ-010 d_req_valid / d_req_ready  input / output  1 each  data-port request handshake.
REQ-011 d_req_addr  input  ADDR_WIDTH; d_req_we  input  1 (1 = store); d_req_wdata  input  DATA_WIDTH; d_req_be  input  DATA_WIDTH/8 byte enables (stores only).
REQ-012 d_resp_valid  output  1  one-cycle pulse; load data valid or store complete.
REQ-013 d_resp_data  output  DATA_WIDTH  load data; 0 for store responses.
REQ-014 ram_address  output  ADDR_WIDTH; ram_data_in  output  DATA_WIDTH; ram_write, ram_read  output  1 each; ram_data_out  input  DATA_WIDTH (registered RAM output, valid the cycle after ram_read).

Function
REQ-015 One transaction in flight at a time; states IDLE, RD_RESP, RMW_WR, WR_RESP.
REQ-016 Requests are accepted only in IDLE; a port's ready is high only in IDLE, only when that port is granted, and is combinational from valid.
REQ-017 Both valid in IDLE: round-robin; the port not granted last wins; with a single valid port, that port wins.
REQ-018 Accept cycle drives ram_address = request address; address, port, we, wdata and be are registered at accept.
REQ-019 Read (either port): ram_read = 1 in accept cycle, then RD_RESP; in RD_RESP the owning port's resp_valid = 1 and its resp_data = ram_data_out; then IDLE (latency 1, throughput one read per 2 cycles).
REQ-020 Store with be all ones: ram_write = 1 and ram_data_in = wdata in accept cycle, then WR_RESP; d_resp_valid = 1 in WR_RESP; then IDLE.
REQ-021 Store with partial be (nonzero, not all ones): ram_read in accept cycle, then RMW_WR; in RMW_WR ram_write = 1, ram_address = registered address, ram_data_in = wdata bytes where be = 1 else ram_data_out bytes; then WR_RESP; then IDLE (latency 2).
REQ-022 Store with be = 0: no RAM access; IDLE -> WR_RESP; d_resp_valid = 1.
REQ-023 Responses cannot be back-pressured; requesters SHALL take them in the pulse cycle.
REQ-024 ram_read and ram_write never both high; neither asserted outside the cycles above.
REQ-025 resp_valid of the non-owning port stays 0; resp_data outputs are 0 when their resp_valid is 0.
REQ-026 d_req_be is ignored for loads; d_req_wdata is ignored for loads.

Reset
REQ-027 While rst is high: state = IDLE, last-grant = data port (so instruction port wins the first contention), all ready, resp_valid, ram_read and ram_write outputs = 0, data outputs = 0.
REQ-028 rst asserted mid-transaction drops it: no response pulse and no RAM write (including a pending RMW_WR) occur in or after the reset cycle.

Structure
REQ-029 Package mem_arb_pkg holds the state enum, the port-ID enum (PORT_I, PORT_D) and the byte-enable width localparam.
REQ-030 Byte merge is sub-module mem_byte_merge (combinational: old word, new word, be -> merged word).

Verification
REQ-031 Reset then i_req_valid with addr 0x10 (mem[0x10] = 0xDEADBEEF) -> i_req_ready in cycle 0, i_resp_valid with 0xDEADBEEF in cycle 1.
REQ-032 Both valid in the same cycle for 3 back-to-back rounds -> grant order I, D, I; no port is starved.
REQ-033 Store addr 0x4, wdata 0x11223344, be 0xF -> ram_write in the accept cycle, d_resp_valid next cycle; a later read returns 0x11223344.
REQ-034 mem[0x8] = 0xAABBCCDD; store wdata 0x000000EE, be 0x1 -> RMW: ram_write in cycle 1 with 0xAABBCCEE, d_resp_valid in cycle 2.
REQ-035 Store be = 0 to addr 0xC -> no ram_write, d_resp_valid in cycle 1, mem[0xC] unchanged.
REQ-036 rst asserted in RMW_WR cycle -> no ram_write, no d_resp_valid; memory unchanged; next request served normally.
